// File: rtl/am9513_legacy_arb.sv
// Two-requester command arbiter/sequencer in front of the Am9513 legacy 9511/9512 shell.
// Define AM9513_LEGACY_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module am9513_legacy_arb #(
  parameter int CMDQ_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req0_valid,
  output logic                              req0_ready,
  input  logic [7:0]                        req0_op,
  input  logic [31:0]                       req0_ctrl,
  input  logic                              req1_valid,
  output logic                              req1_ready,
  input  logic [7:0]                        req1_op,
  input  logic [31:0]                       req1_ctrl,
  output logic                              shell_start,
  output logic [7:0]                        shell_op,
  output logic [31:0]                       shell_ctrl,
  input  logic                              shell_busy,
  input  logic [7:0]                        shell_last_status,
  output logic                              cpl_valid,
  input  logic                              cpl_ready,
  output logic                              cpl_src,
  output logic [7:0]                        cpl_op,
  output logic [7:0]                        cpl_status,
  output logic [$clog2(CMDQ_DEPTH+1)-1:0]   q_count,
  output logic                              q_full,
  output logic                              q_empty
);

  localparam int QCW = $clog2(CMDQ_DEPTH + 1);
  localparam int PW  = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_WAIT,
    S_CPL
  } state_t;

  state_t          state_q;
  logic [QCW-1:0]  count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            src_mem  [CMDQ_DEPTH];
  logic [7:0]      op_mem   [CMDQ_DEPTH];
  logic [31:0]     ctrl_mem [CMDQ_DEPTH];

  logic            shell_start_q;
  logic [7:0]      shell_op_q;
  logic [31:0]     shell_ctrl_q;
  logic            issue_src_q;
  logic            cpl_valid_q;
  logic            cpl_src_q;
  logic [7:0]      cpl_op_q;
  logic [7:0]      cpl_status_q;

  logic            full, empty;
  logic            gnt0, gnt1;
  logic            enq, enq_src, pop;

  assign full  = (count_q == QCW'(CMDQ_DEPTH));
  assign empty = (count_q == '0);

`ifdef AM9513_LEGACY_ARB_FIXED_PRIO_EN
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid && !req0_valid;
`else
  logic rr_q;

  assign gnt0 = req0_valid && (!req1_valid || !rr_q);
  assign gnt1 = req1_valid && (!req0_valid || rr_q);

  // Preference passes to whichever requester lost the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (enq) begin
      rr_q <= !enq_src;
    end
  end
`endif

  // Gated by rst_n so ready reads 0 for the whole reset window, not only after the first edge.
  assign req0_ready = rst_n && !full && gnt0;
  assign req1_ready = rst_n && !full && gnt1;
  assign enq        = req0_ready || req1_ready;
  assign enq_src    = req1_ready;
  assign pop        = (state_q == S_IDLE) && !empty && !shell_busy;

  always_comb begin
    count_d = count_q;
    if (enq && !pop) begin
      count_d = count_q + QCW'(1);
    end else if (pop && !enq) begin
      count_d = count_q - QCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      src_mem[wr_ptr_q]  <= enq_src;
      op_mem[wr_ptr_q]   <= enq_src ? req1_op : req0_op;
      ctrl_mem[wr_ptr_q] <= enq_src ? req1_ctrl : req0_ctrl;
    end
  end

  // Sequencer: one command outstanding at the shell; status is sampled only when the shell holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shell_start_q <= 1'b0;
      shell_op_q    <= '0;
      shell_ctrl_q  <= '0;
      issue_src_q   <= 1'b0;
      cpl_valid_q   <= 1'b0;
      cpl_src_q     <= 1'b0;
      cpl_op_q      <= '0;
      cpl_status_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shell_start_q <= 1'b1;
            shell_op_q    <= op_mem[rd_ptr_q];
            shell_ctrl_q  <= ctrl_mem[rd_ptr_q];
            issue_src_q   <= src_mem[rd_ptr_q];
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          shell_start_q <= 1'b0;
          state_q       <= S_CHECK;
        end
        S_CHECK, S_WAIT: begin
          if (!shell_busy) begin
            cpl_valid_q  <= 1'b1;
            cpl_src_q    <= issue_src_q;
            cpl_op_q     <= shell_op_q;
            cpl_status_q <= shell_last_status;
            state_q      <= S_CPL;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_CPL: begin
          if (cpl_ready) begin
            cpl_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign shell_start = shell_start_q;
  assign shell_op    = shell_op_q;
  assign shell_ctrl  = shell_ctrl_q;
  assign cpl_valid   = cpl_valid_q;
  assign cpl_src     = cpl_src_q;
  assign cpl_op      = cpl_op_q;
  assign cpl_status  = cpl_status_q;
  assign q_count     = count_q;
  assign q_full      = full;
  assign q_empty     = empty;

endmodule

// File: tb/tb_am9513_legacy_arb.sv
// Randomized bench for am9513_legacy_arb with a queue-based reference model and a behavioural shell.
module tb_am9513_legacy_arb;

  localparam int          DEPTH  = 4;
  localparam logic [7:0]  OP_ADD = 8'h6C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_op, req1_op;
  logic [31:0] req0_ctrl, req1_ctrl;
  logic        shell_start, shell_busy;
  logic [7:0]  shell_op, shell_last_status;
  logic [31:0] shell_ctrl;
  logic        cpl_valid, cpl_ready, cpl_src;
  logic [7:0]  cpl_op, cpl_status;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic        q_full, q_empty;

  always #5 clk = ~clk;

  am9513_legacy_arb #(.CMDQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_ctrl(req1_ctrl),
    .shell_start(shell_start), .shell_op(shell_op), .shell_ctrl(shell_ctrl),
    .shell_busy(shell_busy), .shell_last_status(shell_last_status),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_src(cpl_src), .cpl_op(cpl_op),
    .cpl_status(cpl_status), .q_count(q_count), .q_full(q_full), .q_empty(q_empty)
  );

  typedef struct packed {
    logic        src;
    logic [7:0]  op;
    logic [31:0] ctrl;
  } cmd_t;

  // Reference model state
  cmd_t       m_q[$];
  cmd_t       m_inf;
  bit         m_inflight;
  int         m_L;
  logic [7:0] m_st;
  int         m_acc, m_pop;
  bit         m_pref;
  int         cyc, start_cyc;
  bit         cpl_seen;
  bit         acc0, acc1;

  // Stimulus knobs and shell model
  int         p_v0, p_v1, p_cr, sh_fix, send0;
  bit         sh_err_en;
  logic [7:0] send_op;
  bit         sh_flag;
  int         sh_rem;

  int         n_chk, n_err;
  int         glog[$];
  bit         glog_en;
  logic       last_src;
  logic [7:0] last_op, last_st;
  int         last_lat, n_cpl;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] garbage();
    return 8'hA0 | 8'($urandom_range(15, 0));
  endfunction

  always @(negedge clk) begin
    int   cnt;
    bit   er0, er1;
    cmd_t c;
    cyc++;
    if (!rst_n) begin
      m_q.delete();
      m_inflight = 0; m_acc = 0; m_pop = 0; m_pref = 0;
      acc0 = 0; acc1 = 0; cpl_seen = 0;
    end else begin
      if (shell_start) begin
        check_eq("one_outstanding", m_inflight, 0);
        if (m_q.size() == 0) begin
          check_eq("start_without_cmd", 1, 0);
        end else begin
          check_eq("shell_op", shell_op, m_q[0].op);
          check_eq("shell_ctrl", shell_ctrl, m_q[0].ctrl);
          m_inf = m_q.pop_front();
          m_inflight = 1;
          m_pop++;
          m_L  = (sh_fix >= 0) ? sh_fix : int'($urandom_range(5, 0));
          m_st = (m_L == 0) ? 8'h01 :
                 ((sh_err_en && $urandom_range(3, 0) == 0) ? 8'h02 : 8'h00);
          sh_flag   = 1;
          start_cyc = cyc;
          cpl_seen  = 0;
        end
      end
      cnt = m_acc - m_pop;
      check_eq("q_count", q_count, cnt);
      check_eq("q_full", q_full, cnt == DEPTH);
      check_eq("q_empty", q_empty, cnt == 0);
`ifdef AM9513_LEGACY_ARB_FIXED_PRIO_EN
      er0 = (cnt != DEPTH) && req0_valid;
      er1 = (cnt != DEPTH) && req1_valid && !req0_valid;
`else
      er0 = (cnt != DEPTH) && req0_valid && (!req1_valid || m_pref == 0);
      er1 = (cnt != DEPTH) && req1_valid && (!req0_valid || m_pref == 1);
`endif
      check_eq("req0_ready", req0_ready, er0);
      check_eq("req1_ready", req1_ready, er1);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0 || acc1) begin
        c.src  = acc1;
        c.op   = acc1 ? req1_op : req0_op;
        c.ctrl = acc1 ? req1_ctrl : req0_ctrl;
        m_q.push_back(c);
        m_acc++;
        m_pref = !acc1;
        if (glog_en) glog.push_back(int'(acc1));
      end
      check_eq("cpl_stray", cpl_valid && !m_inflight, 0);
      if (m_inflight && cpl_valid) begin
        if (!cpl_seen) begin
          check_eq("cpl_latency", cyc - start_cyc, m_L + 2);
          last_lat = cyc - start_cyc;
          cpl_seen = 1;
        end
        check_eq("cpl_src", cpl_src, m_inf.src);
        check_eq("cpl_op", cpl_op, m_inf.op);
        check_eq("cpl_status", cpl_status, m_st);
        if (cpl_ready) begin
          m_inflight = 0;
          cpl_seen   = 0;
          last_src   = cpl_src;
          last_op    = cpl_op;
          last_st    = cpl_status;
          n_cpl++;
        end
      end else if (m_inflight && cpl_seen) begin
        check_eq("cpl_hold", cpl_valid, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      shell_busy = 0; shell_last_status = 8'h00; sh_flag = 0; sh_rem = 0;
    end else if (sh_flag) begin
      sh_flag = 0;
      if (m_L == 0) begin
        shell_busy = 0; shell_last_status = m_st;
      end else begin
        shell_busy = 1; sh_rem = m_L - 1; shell_last_status = garbage();
      end
    end else if (shell_busy) begin
      if (sh_rem == 0) begin
        shell_busy = 0; shell_last_status = m_st;
      end else begin
        sh_rem--; shell_last_status = garbage();
      end
    end else begin
      shell_last_status = garbage();
    end
    if (!(req0_valid && !acc0)) begin
      if (send0 > 0) begin
        req0_valid = 1; req0_op = send_op; req0_ctrl = $urandom(); send0--;
      end else if (int'($urandom_range(99, 0)) < p_v0) begin
        req0_valid = 1; req0_op = 8'($urandom()); req0_ctrl = $urandom();
      end else begin
        req0_valid = 0;
      end
    end
    if (!(req1_valid && !acc1)) begin
      if (int'($urandom_range(99, 0)) < p_v1) begin
        req1_valid = 1; req1_op = 8'($urandom()); req1_ctrl = $urandom();
      end else begin
        req1_valid = 0;
      end
    end
    cpl_ready = (int'($urandom_range(99, 0)) < p_cr);
  endtask

  task automatic wait_idle();
    bit idle;
    p_v0 = 0; p_v1 = 0; p_cr = 100;
    idle = 0;
    for (int i = 0; i < 400 && !idle; i++) begin
      tick();
      idle = !m_inflight && (m_q.size() == 0) && !req0_valid && !req1_valid && !cpl_valid;
    end
    check_eq("idle_reached", idle, 1);
  endtask

  task automatic wait_cpl(input string tag);
    int c0;
    c0 = n_cpl;
    for (int i = 0; i < 100 && n_cpl == c0; i++) tick();
    check_eq(tag, n_cpl > c0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req0_ready"}, req0_ready, 0);
    check_eq({pfx, "_req1_ready"}, req1_ready, 0);
    check_eq({pfx, "_shell_start"}, shell_start, 0);
    check_eq({pfx, "_shell_op"}, shell_op, 0);
    check_eq({pfx, "_shell_ctrl"}, shell_ctrl, 0);
    check_eq({pfx, "_cpl_valid"}, cpl_valid, 0);
    check_eq({pfx, "_cpl_src"}, cpl_src, 0);
    check_eq({pfx, "_cpl_op"}, cpl_op, 0);
    check_eq({pfx, "_cpl_status"}, cpl_status, 0);
    check_eq({pfx, "_q_count"}, q_count, 0);
    check_eq({pfx, "_q_full"}, q_full, 0);
    check_eq({pfx, "_q_empty"}, q_empty, 1);
  endtask

  initial begin
    int         g, c0;
    bit         seen;
    logic       h_src;
    logic [7:0] h_op, h_st;
    rst_n = 0;
    req0_valid = 1; req0_op = 8'h11; req0_ctrl = 32'h1111_0000;
    req1_valid = 1; req1_op = 8'h22; req1_ctrl = 32'h2222_0000;
    cpl_ready = 0; shell_busy = 0; shell_last_status = 8'h00;
    p_v0 = 0; p_v1 = 0; p_cr = 100; sh_fix = -1; sh_err_en = 1; send0 = 0; send_op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;

    // Round-robin with both requesters saturating
    p_v0 = 100; p_v1 = 100; p_cr = 100; sh_fix = 4; sh_err_en = 0; glog_en = 1;
    repeat (40) tick();
    glog_en = 0;
    for (int i = 0; i < 4; i++) begin
      g = (i < glog.size()) ? glog[i] : 9;
`ifdef AM9513_LEGACY_ARB_FIXED_PRIO_EN
      check_eq($sformatf("grant%0d", i), g, 0);
`else
      check_eq($sformatf("grant%0d", i), g, i % 2);
`endif
    end
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = q_full;
    end
    check_eq("rr_reaches_full", seen, 1);
    #3;
    check_eq("full_req0_ready", req0_ready, 0);
    check_eq("full_req1_ready", req1_ready, 0);

    // Underflow reject
    wait_idle();
    sh_fix = 0; send_op = OP_ADD; send0 = 1;
    wait_cpl("underflow_cpl");
    check_eq("underflow_status", last_st, 8'h01);
    check_eq("underflow_src", last_src, 0);
    check_eq("underflow_latency", last_lat, 2);

    // Normal two-operand ADD
    wait_idle();
    sh_fix = 4; sh_err_en = 0; send_op = OP_ADD; send0 = 1;
    wait_cpl("add_cpl");
    check_eq("add_status", last_st, 8'h00);
    check_eq("add_op", last_op, OP_ADD);
    check_eq("add_latency", last_lat, 6);

    // Completion backpressure
    wait_idle();
    sh_fix = -1; sh_err_en = 1; p_cr = 0; p_v0 = 100; p_v1 = 100;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = cpl_valid;
    end
    check_eq("bp_cpl_seen", seen, 1);
    h_src = cpl_src; h_op = cpl_op; h_st = cpl_status;
    repeat (10) tick();
    check_eq("bp_cpl_valid", cpl_valid, 1);
    check_eq("bp_cpl_src", cpl_src, h_src);
    check_eq("bp_cpl_op", cpl_op, h_op);
    check_eq("bp_cpl_status", cpl_status, h_st);
    check_eq("bp_q_full", q_full, 1);

    // FIFO wrap and long random traffic
    c0 = n_cpl;
    for (int blk = 0; blk < 16; blk++) begin
      p_v0 = $urandom_range(100, 0);
      p_v1 = $urandom_range(100, 0);
      p_cr = $urandom_range(100, 20);
      repeat (100) tick();
    end
    check_eq("wrap_progress", (n_cpl - c0) >= 7, 1);

    // Reset in the middle of a busy window
    wait_idle();
    sh_fix = 5; send_op = OP_ADD; send0 = 1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = shell_busy;
    end
    check_eq("midreset_busy_seen", seen, 1);
    tick();
    tick();
    req0_valid = 1; req1_valid = 1;
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    req0_valid = 0; req1_valid = 0; p_v0 = 0; p_v1 = 0;
    repeat (3) tick();
    #2;
    rst_n = 1;
    repeat (10) tick();
    check_eq("post_reset_q_empty", q_empty, 1);
    check_eq("post_reset_cpl_valid", cpl_valid, 0);
    check_eq("post_reset_start", shell_start, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/am9513_legacy_arb.md
# am9513_legacy_arb

Two-requester command arbiter and sequencer for the Am9513 legacy 9511/9512 stack shell. It accepts legacy commands (op + ctrl) from two independent requesters, queues them in a small FIFO, and issues them one at a time to the legacy shell. It tracks each command through the shell's busy window and returns a completion record carrying the shell's one-cycle `last_status`. It sits between the CSR/host front end (requester 0), the alternate command source (requester 1) and `am9513_legacy_shell`.

## Interface
- `CMDQ_DEPTH`, 4 — command FIFO entries; power of two, ≥2.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `req0_valid` in 1 — requester 0 offers a command.
- `req0_ready` out 1 — requester 0 command accepted this cycle.
- `req0_op` in 8 — legacy opcode.
- `req0_ctrl` in 32 — legacy ctrl word.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_ctrl` — same as requester 0.
- `shell_start` out 1 — one-cycle start pulse to the shell.
- `shell_op` out 8 — opcode presented with `shell_start`.
- `shell_ctrl` out 32 — ctrl presented with `shell_start`.
- `shell_busy` in 1 — shell busy.
- `shell_last_status` in 8 — shell status; valid only in the cycles defined under Timing.
- `cpl_valid` out 1 — completion record valid.
- `cpl_ready` in 1 — completion consumer accepts.
- `cpl_src` out 1 — requester index of the completed command.
- `cpl_op` out 8 — opcode of the completed command.
- `cpl_status` out 8 — captured shell status: 00 ok, 01 underflow, 02 exec error.
- `q_count` out $clog2(CMDQ_DEPTH+1) — FIFO occupancy.
- `q_full` out 1 — `q_count == CMDQ_DEPTH`.
- `q_empty` out 1 — `q_count == 0`.

## Operation
- **FIFO entry:** {src, op, ctrl}.
- **Enqueue:** at most one entry per cycle.
  - `reqN_ready` is asserted combinationally only for the granted requester, and only when `!q_full` from the registered count.
  - There is no full-bypass: a dequeue and an enqueue in the same cycle while full are not possible.
- **Arbitration:** round-robin.
  - `rr_q` names the preferred requester. If both requesters are valid, `rr_q` wins.
  - After any grant, `rr_q` becomes the non-granted index. `rr_q` resets to 0.
- **Simultaneous enqueue and dequeue** (not full): `q_count` is unchanged, and both pointers advance, wrapping mod `CMDQ_DEPTH`.
- **Sequencer FSM:**
  - `S_IDLE`: if `!q_empty && !shell_busy`, pop the head into an issue register and go to `S_ISSUE`.
  - `S_ISSUE`: `shell_start=1` with the registered op/ctrl, then go to `S_CHECK`.
  - `S_CHECK`:
    - If `!shell_busy` (underflow reject), capture `shell_last_status` and go to `S_CPL`.
    - Otherwise go to `S_WAIT`.
  - `S_WAIT`: on the first cycle with `!shell_busy`, capture `shell_last_status` and go to `S_CPL`.
  - `S_CPL`: `cpl_valid=1` with src, op and status held stable. On `cpl_ready`, go to `S_IDLE`.
- Only one command is outstanding at the shell at any time. New enqueues continue during every state.
- **Reset mid-operation:** all state is cleared and the queue is discarded. The shell shares `rst_n`, so no in-flight command survives.

## Timing
- **Reset values:**
  - `req*_ready=0`, `shell_start=0`, `shell_op=0`, `shell_ctrl=0`.
  - `cpl_valid=0`, `cpl_src=0`, `cpl_op=0`, `cpl_status=0`.
  - `q_count=0`, `q_full=0`, `q_empty=1`.
- Enqueue at edge T makes `q_empty=0` at T+1. Earliest `shell_start` is at T+2 (`S_IDLE` pop, then `S_ISSUE`).
- **Status sampling:** the shell holds `last_status` for exactly one cycle after it returns to idle, or after a rejected start. The block samples it only in those cycles:
  - `S_CHECK`, which is start+1.
  - The first non-busy cycle in `S_WAIT`.
- **Minimum latencies:**
  - Underflow reject: `shell_start` to `cpl_valid` is 2 cycles.
  - Two-operand op (shell busy for POP0, POP1, EXEC, PUSH = 4 cycles): `cpl_valid` 6 cycles after `shell_start`.
- `cpl_valid` stays high until `cpl_ready` is sampled high, with no deassertion in between.
- Back-to-back issue spacing is at least 1 `S_IDLE` cycle after the completion handshake.

## Configuration
- **`AM9513_LEGACY_ARB_FIXED_PRIO_EN` defined:** requester 0 always wins simultaneous requests, and `rr_q` is removed.
- **Undefined:** round-robin as specified above.

## Test plan
- **Round-robin:** hold `req0_valid` and `req1_valid` high continuously with depth 4 and `cpl_ready=1`. Required grants: src 0,1,0,1, then ready drops while `q_full=1`.
- **Underflow:** send ADD with an empty shell stack. Required: `shell_start` pulse, `shell_busy` stays 0, `cpl_valid` 2 cycles later with `cpl_status=8'h01`, `cpl_src=0`.
- **Normal ADD:** pre-push 2 operands and issue ADD. Required: `cpl_valid` 6 cycles after start, `cpl_status=8'h00`, `cpl_op` equal to the ADD opcode.
- **Completion backpressure:** hold `cpl_ready=0` for 10 cycles after `cpl_valid`. Required: record stable, no second `shell_start`, enqueues still accepted until full.
- **FIFO wrap:** push 7 commands through depth 4 with concurrent enqueue and dequeue. Required: completions arrive in enqueue order, with `q_count` never above 4.
- **Reset mid-operation:** assert `rst_n=0` during `S_WAIT`. Required: all outputs at reset values asynchronously, and after release `q_empty=1` with no stray `cpl_valid`.
